// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
// Width constants keep generator and capture consistent: a capture counter one
// bit wider than the generator counter can measure a full generator period.
package pwm_pkg;

  localparam int unsigned PWM_COUNTER_WIDTH = 8;
  localparam int unsigned PWM_MEAS_WIDTH    = PWM_COUNTER_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchroniser and edge detector for an asynchronous single-bit input.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : asynchronous input
//   s          : synchronised level, time-aligned with rise/fall
//   rise, fall : one-cycle edge flags of the synchronised level
module pwm_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic                   s_d;

  assign s_sync = sync_q[SYNC_STAGES-1];

  // Edge flags are registered; s is taken from the delayed copy so the level
  // seen alongside a flag is the post-edge level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      s_d    <= s_sync;
      rise   <= s_sync & ~s_d;
      fall   <= ~s_sync & s_d;
    end
  end

  assign s = s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of pwm_i in clk cycles and
// reports them once per completed period (rising edge to rising edge).
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable_i       : capture enable; low returns the capture FSM to IDLE
//   pwm_i          : asynchronous PWM input
//   period_o       : last completed period in cycles
//   high_o         : high time within that period
//   valid_o        : one-cycle pulse when period_o/high_o update
//   stuck_o        : one-cycle pulse when no edge arrives within counter range
//   stuck_level_o  : level of the input at the time stuck_o pulses
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MEAS_WIDTH  = PWM_MEAS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  pwm_i,
  output logic [MEAS_WIDTH-1:0] period_o,
  output logic [MEAS_WIDTH-1:0] high_o,
  output logic                  valid_o,
  output logic                  stuck_o,
  output logic                  stuck_level_o
);

  localparam logic [MEAS_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [MEAS_WIDTH-1:0] CNT_ONE = MEAS_WIDTH'(1);

  cap_state_e            state;
  logic [MEAS_WIDTH-1:0] cnt;
  logic [MEAS_WIDTH-1:0] cnt_inc;
  logic [MEAS_WIDTH-1:0] high_cnt;
  logic                  s;
  logic                  rise;
  logic                  fall;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (pwm_i),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      high_cnt      <= '0;
      period_o      <= '0;
      high_o        <= '0;
      valid_o       <= 1'b0;
      stuck_o       <= 1'b0;
      stuck_level_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      stuck_o <= 1'b0;
      if (!enable_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (rise) begin
              state <= HIGH;
              cnt   <= CNT_ONE;
            end
          end
          HIGH, LOW: begin
            // An edge takes priority over saturation, so a period of exactly
            // CNT_MAX cycles is still reported.
            if (rise) begin
              state <= HIGH;
              cnt   <= CNT_ONE;
              if (state == LOW) begin
                period_o <= cnt;
                high_o   <= high_cnt;
                valid_o  <= 1'b1;
              end
            end else if (fall) begin
              cnt <= cnt_inc;
              if (state == HIGH) begin
                high_cnt <= cnt;
                state    <= LOW;
              end
            end else if (cnt == CNT_MAX) begin
              stuck_o       <= 1'b1;
              stuck_level_o <= s;
              state         <= IDLE;
              cnt           <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned MEAS_WIDTH  = 9;
  localparam int          SAT         = (1 << MEAS_WIDTH) - 1;
  localparam int          LAT         = SYNC_STAGES + 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  enable_i;
  logic                  pwm_i;
  logic [MEAS_WIDTH-1:0] period_o;
  logic [MEAS_WIDTH-1:0] high_o;
  logic                  valid_o;
  logic                  stuck_o;
  logic                  stuck_level_o;

  always #5 clk = ~clk;

  pwm_capture #(
    .SYNC_STAGES(SYNC_STAGES),
    .MEAS_WIDTH (MEAS_WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .pwm_i        (pwm_i),
    .period_o     (period_o),
    .high_o       (high_o),
    .valid_o      (valid_o),
    .stuck_o      (stuck_o),
    .stuck_level_o(stuck_level_o)
  );

  typedef struct { int p; int h; int t; } rep_t;
  typedef struct { logic lvl; int t; } stk_t;
  typedef struct { int hi; int lo; int reps; int exp_p; int exp_h; } vec_t;

  rep_t rep_q[$];
  stk_t stk_q[$];
  rep_t mr;
  stk_t ms;
  vec_t tv[7];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state, advanced once per driven input cycle.
  logic m_prev = 1'b0;
  bit   m_en = 1'b1;
  bit   m_armed = 1'b0;
  int   m_dist = 0;
  int   m_hi = 0;
  int   m_last_p = 0;
  int   m_last_h = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic model(input logic lvl);
    logic rise, fall;
    rise   = lvl & ~m_prev;
    fall   = ~lvl & m_prev;
    m_prev = lvl;
    if (!m_en) begin
      m_armed = 1'b0;
    end else if (m_armed) begin
      m_dist++;
      if (rise) begin
        rep_q.push_back('{sat(m_dist), sat(m_hi), cyc});
        m_last_p = sat(m_dist);
        m_last_h = sat(m_hi);
        m_dist   = 0;
      end else if (fall) begin
        m_hi = m_dist;
      end else if (m_dist >= SAT) begin
        stk_q.push_back('{lvl, cyc});
        m_armed = 1'b0;
      end
    end else if (rise) begin
      m_armed = 1'b1;
      m_dist  = 0;
    end
  endtask

  task automatic step(input logic lvl);
    @(negedge clk);
    pwm_i = lvl;
    model(lvl);
  endtask

  task automatic hold(input logic lvl, input int n);
    repeat (n) step(lvl);
  endtask

  task automatic periods(input int hi, input int lo, input int n);
    repeat (n) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  task automatic check_hold(input string name);
    check({name, "_period"}, int'(period_o), m_last_p);
    check({name, "_high"}, int'(high_o), m_last_h);
  endtask

  // Scoreboard side: every valid_o/stuck_o pulse must match a queued expectation.
  always @(negedge clk) begin
    if (valid_o) begin
      if (rep_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mr = rep_q.pop_front();
        check("period", int'(period_o), mr.p);
        check("high", int'(high_o), mr.h);
        check("valid_latency", cyc - mr.t, LAT);
      end
    end
    if (stuck_o) begin
      if (stk_q.size() == 0) begin
        check("unexpected_stuck", 1, 0);
      end else begin
        ms = stk_q.pop_front();
        check("stuck_level", int'(stuck_level_o), int'(ms.lvl));
        check("stuck_latency", cyc - ms.t, LAT);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tv[0] = '{3, 7, 4, 10, 3};
    tv[1] = '{192, 64, 3, 256, 192};
    tv[2] = '{1, 255, 3, 256, 1};
    tv[3] = '{255, 1, 3, 256, 255};
    tv[4] = '{1, 1, 4, 2, 1};
    tv[5] = '{5, 1, 3, 6, 5};
    tv[6] = '{100, 411, 3, 511, 100};

    rst_n    = 1'b0;
    enable_i = 1'b1;
    pwm_i    = 1'b0;
    #1;
    check("reset_period", int'(period_o), 0);
    check("reset_high", int'(high_o), 0);
    check("reset_valid", int'(valid_o), 0);
    check("reset_stuck", int'(stuck_o), 0);
    check("reset_stuck_level", int'(stuck_level_o), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven waveforms; the final entry ends in a low phase long enough
    // to saturate the counter.
    for (int i = 0; i < 7; i++) begin
      periods(tv[i].hi, tv[i].lo, tv[i].reps);
      hold(1'b0, 6);
      check("tbl_period", int'(period_o), tv[i].exp_p);
      check("tbl_high", int'(high_o), tv[i].exp_h);
    end
    check("tbl_stuck_seen", stk_q.size(), 0);

    // Stuck high, then a new waveform, then stuck low.
    periods(4, 6, 3);
    hold(1'b1, 600);
    check("stuck_hi_seen", stk_q.size(), 0);
    check_hold("stuck_hi_hold");
    periods(2, 8, 3);
    hold(1'b0, 600);
    check("stuck_lo_seen", stk_q.size(), 0);
    check("resume_period", int'(period_o), 10);
    check("resume_high", int'(high_o), 2);

    // Enable dropped mid-low, waveform continues while disabled.
    periods(6, 10, 2);
    hold(1'b1, 6);
    hold(1'b0, 5);
    enable_i = 1'b0;
    m_en     = 1'b0;
    hold(1'b0, 5);
    periods(3, 9, 3);
    hold(1'b0, 6);
    check_hold("disabled_hold");
    enable_i = 1'b1;
    m_en     = 1'b1;
    periods(6, 10, 3);
    hold(1'b0, 6);
    check("reenable_period", int'(period_o), 16);
    check("reenable_high", int'(high_o), 6);

    // Reset asserted while the capture is in its low phase.
    periods(5, 20, 2);
    hold(1'b1, 5);
    hold(1'b0, 8);
    check("prereset_period", int'(period_o), 25);
    rst_n = 1'b0;
    #1;
    check("midrst_period", int'(period_o), 0);
    check("midrst_high", int'(high_o), 0);
    check("midrst_valid", int'(valid_o), 0);
    check("midrst_stuck", int'(stuck_o), 0);
    m_armed  = 1'b0;
    m_prev   = 1'b0;
    m_last_p = 0;
    m_last_h = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 3);
    hold(1'b0, 6);
    check_hold("postrst_first_rise");
    periods(6, 10, 3);
    hold(1'b0, 10);
    check("postrst_period", int'(period_o), 16);
    check("postrst_high", int'(high_o), 6);

    check("pending_reports", rep_q.size(), 0);
    check("pending_stuck", stk_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
